// File: rtl/usb_tx_pkt_ctrl.sv
// ----------------------------------------------------------------------------
// usb_tx_pkt_ctrl
//
// USB transmit packet controller. On a start request it sends a PID byte,
// streams the payload from the packet source straight through to the PHY,
// optionally appends the CRC16 of the payload, and then holds the line idle
// for a fixed inter-packet gap before it will accept another request.
//
// Parameters:
//   HIST_W  - depth of the tx_valid history register buff (>= 2)
//   MAX_LEN - maximum payload bytes per packet (1..1023)
//   IPG     - idle cycles forced after each packet (0..15)
//   CRC_EN  - 1 appends CRC16 after the payload, 0 skips the CRC bytes
//
// Ports:
//   clk, reset        - single rising-edge clock, async active-high reset
//   send_data         - start request, only looked at while idle
//   pid, zlp          - packet ID and zero-length flag, captured at start
//   s_data/s_valid/s_last/s_ready - payload stream from the packet source
//   tx_data/tx_valid/tx_ready     - byte stream toward the PHY
//   busy              - high whenever a packet or gap is in progress
//   len_err           - sticky, payload was cut off at MAX_LEN
//   byte_cnt          - payload bytes sent in the current or last packet
//   buff              - tx_valid history, buff[0] is the newest sample
// ----------------------------------------------------------------------------
module usb_tx_pkt_ctrl #(
    parameter int HIST_W  = 10,
    parameter int MAX_LEN = 64,
    parameter int IPG     = 2,
    parameter int CRC_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_data,
    input  logic [3:0]        pid,
    input  logic              zlp,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              len_err,
    output logic [9:0]        byte_cnt,
    output logic [HIST_W-1:0] buff
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_GAP
    } state_t;

    localparam logic [9:0] MAX_CNT  = 10'(MAX_LEN);
    localparam logic [9:0] LAST_CNT = 10'(MAX_LEN - 1);
    localparam logic [3:0] GAP_LOAD = (IPG > 0) ? 4'(IPG - 1) : 4'd0;

    // Where to go once the last byte of a packet has been handed over: with
    // no gap configured the controller is ready again immediately.
    localparam state_t POST_CRC     = (IPG > 0) ? ST_GAP : ST_IDLE;
    localparam state_t POST_PAYLOAD = (CRC_EN != 0) ? ST_CRC_LO : POST_CRC;

    state_t      state;
    logic [3:0]  pid_q;
    logic        zlp_q;
    logic [15:0] crc;
    logic [3:0]  gap_cnt;

    // CRC-16/USB, reflected form of polynomial 0x8005, one byte at a time
    // with the least significant bit going first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Output decode. The payload phase is a pure pass-through so the source
    // sees the PHY's back-pressure in the same cycle; every other state
    // drives bytes held in registers, which keeps them stable while stalled.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        s_ready  = 1'b0;
        case (state)
            ST_PID: begin
                tx_valid = 1'b1;
                tx_data  = {~pid_q, pid_q};
            end
            ST_DATA: begin
                tx_valid = s_valid;
                tx_data  = s_data;
                s_ready  = tx_ready;
            end
            ST_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = ~crc[7:0];
            end
            ST_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = ~crc[15:8];
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Packet sequencing. A payload ends either on the source's last flag or
    // when MAX_LEN bytes have gone out; in the latter case any remaining
    // source bytes stay put for the next packet and len_err records the cut.
    // The gap counter is preloaded in every other state so GAP always starts
    // with a full count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pid_q    <= 4'h0;
            zlp_q    <= 1'b0;
            crc      <= 16'hFFFF;
            byte_cnt <= 10'd0;
            len_err  <= 1'b0;
            gap_cnt  <= 4'd0;
        end else begin
            if (state != ST_GAP) begin
                gap_cnt <= GAP_LOAD;
            end
            case (state)
                ST_IDLE: begin
                    if (send_data) begin
                        pid_q    <= pid;
                        zlp_q    <= zlp;
                        byte_cnt <= 10'd0;
                        len_err  <= 1'b0;
                        crc      <= 16'hFFFF;
                        state    <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (tx_ready) begin
                        state <= zlp_q ? POST_PAYLOAD : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (s_valid && tx_ready) begin
                        crc <= crc16_byte(crc, s_data);
                        if (byte_cnt != MAX_CNT) begin
                            byte_cnt <= byte_cnt + 10'd1;
                        end
                        if (s_last || (byte_cnt == LAST_CNT)) begin
                            state <= POST_PAYLOAD;
                            if (!s_last) begin
                                len_err <= 1'b1;
                            end
                        end
                    end
                end
                ST_CRC_LO: begin
                    if (tx_ready) begin
                        state <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (tx_ready) begin
                        state <= POST_CRC;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Shift history of tx_valid, sampled every cycle with the newest sample
    // entering at bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buff <= '0;
        end else begin
            buff <= {buff[HIST_W-2:0], tx_valid};
        end
    end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_usb_tx_pkt_ctrl
//
// Self-checking bench for usb_tx_pkt_ctrl. Two instances share one stimulus
// bus: dut_a uses the default parameters, dut_b uses MAX_LEN=4 and IPG=0 so
// truncation and the no-gap path can be exercised. sel_b picks which
// instance the source/PHY models follow. Expected bytes are built from a
// payload queue and a bit-serial CRC-16/USB model.
// ----------------------------------------------------------------------------
module tb_usb_tx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       send_data;
    logic [3:0] pid;
    logic       zlp;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       tx_ready;

    logic       a_s_ready, a_tx_valid, a_busy, a_len_err;
    logic [7:0] a_tx_data;
    logic [9:0] a_byte_cnt, a_buff;
    logic       b_s_ready, b_tx_valid, b_busy, b_len_err;
    logic [7:0] b_tx_data;
    logic [9:0] b_byte_cnt, b_buff;

    logic       sel_b;
    logic       o_s_ready, o_tx_valid, o_busy, o_len_err;
    logic [7:0] o_tx_data;
    logic [9:0] o_byte_cnt, o_buff;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [8:0] src_q[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [9:0] hist_model;
    logic [9:0] buff_exp;
    int         ready_mode;
    int         valid_mode;
    bit         hold_send;
    bit         src_hold;
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         saw_s_ready;

    usb_tx_pkt_ctrl #(.HIST_W(10), .MAX_LEN(64), .IPG(2), .CRC_EN(1)) dut_a (
        .clk(clk), .reset(reset), .send_data(send_data), .pid(pid), .zlp(zlp),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(a_s_ready),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
        .busy(a_busy), .len_err(a_len_err), .byte_cnt(a_byte_cnt), .buff(a_buff)
    );

    usb_tx_pkt_ctrl #(.HIST_W(10), .MAX_LEN(4), .IPG(0), .CRC_EN(1)) dut_b (
        .clk(clk), .reset(reset), .send_data(send_data), .pid(pid), .zlp(zlp),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(b_s_ready),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
        .busy(b_busy), .len_err(b_len_err), .byte_cnt(b_byte_cnt), .buff(b_buff)
    );

    assign o_s_ready  = sel_b ? b_s_ready  : a_s_ready;
    assign o_tx_valid = sel_b ? b_tx_valid : a_tx_valid;
    assign o_busy     = sel_b ? b_busy     : a_busy;
    assign o_len_err  = sel_b ? b_len_err  : a_len_err;
    assign o_tx_data  = sel_b ? b_tx_data  : a_tx_data;
    assign o_byte_cnt = sel_b ? b_byte_cnt : a_byte_cnt;
    assign o_buff     = sel_b ? b_buff     : a_buff;

    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-16/USB: feedback is the register LSB xor the incoming
    // data bit, data bits taken LSB first.
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        bit          fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return {24'h0, got[i]};
        return 32'hxxxxxxxx;
    endfunction

    // Expected PHY byte sequence for the packet about to start, taken from
    // the front of the source queue without consuming it.
    task automatic build_expected(input logic [3:0] p, input logic z, input int max_len,
                                  output int n, output bit err);
        logic [15:0] crc;
        exp_q.delete();
        exp_q.push_back({~p, p});
        crc = 16'hFFFF;
        n   = 0;
        err = 1'b0;
        if (!z) begin
            for (int i = 0; i < src_q.size(); i++) begin
                exp_q.push_back(src_q[i][7:0]);
                crc = ref_crc(crc, src_q[i][7:0]);
                n++;
                if (src_q[i][8]) break;
                if (n == max_len) begin
                    err = 1'b1;
                    break;
                end
            end
        end
        exp_q.push_back(~crc[7:0]);
        exp_q.push_back(~crc[15:8]);
    endtask

    // One clock cycle: drive inputs just after the rising edge, observe the
    // selected instance on the falling edge and update the models.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        send_data = hold_send;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
        if (!src_hold) begin
            if (src_q.size() > 0 && (valid_mode == 0 || $urandom_range(0, 3) != 0)) begin
                s_valid           = 1'b1;
                {s_last, s_data}  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        cyc++;
        buff_exp = hist_model;
        if (prev_stall) checkOutput("stall_hold", {23'h0, o_tx_valid, o_tx_data}, {23'h0, 1'b1, prev_data});
        prev_stall = o_tx_valid && !tx_ready;
        prev_data  = o_tx_data;
        if (o_tx_valid && tx_ready) got.push_back(o_tx_data);
        if (o_s_ready) saw_s_ready = 1'b1;
        src_hold = s_valid && !o_s_ready;
        if (s_valid && o_s_ready) void'(src_q.pop_front());
        hist_model = reset ? 10'h0 : {hist_model[8:0], o_tx_valid};
    endtask

    // Runs one complete packet on the selected instance and checks it.
    task automatic run_packet(input logic [3:0] p, input logic z, input bit hold);
        int n;
        bit err;
        int gaps;
        int guard;
        bit full_before;
        guard = 0;
        while (o_busy && guard < 300) begin
            applyStimulus();
            guard++;
        end
        build_expected(p, z, sel_b ? 4 : 64, n, err);
        got.delete();
        saw_s_ready = 1'b0;
        pid       = p;
        zlp       = z;
        send_data = 1'b1;
        hold_send = hold;
        applyStimulus();
        checkOutput("start_latency", {23'h0, o_tx_valid, o_tx_data}, {23'h0, 1'b1, ~p, p});
        gaps  = 0;
        guard = 0;
        while (o_busy && guard < 300) begin
            full_before = (got.size() >= exp_q.size());
            applyStimulus();
            if (full_before && o_busy) gaps++;
            guard++;
        end
        checkOutput("packet_end_busy", {31'h0, o_busy}, 32'h0);
        checkOutput("gap_cycles", gaps, sel_b ? 0 : 2);
        checkOutput("tx_byte_total", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput($sformatf("tx_byte%0d", i), got_at(i), {24'h0, exp_q[i]});
        end
        checkOutput("byte_cnt", {22'h0, o_byte_cnt}, n);
        checkOutput("len_err", {31'h0, o_len_err}, {31'h0, err});
        checkOutput("buff", {22'h0, o_buff}, {22'h0, buff_exp});
        checkOutput("idle_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        if (z) checkOutput("zlp_s_ready", {31'h0, saw_s_ready}, 32'h0);
    endtask

    task automatic load_vector();
        for (int v = 8'h31; v <= 8'h39; v++) src_q.push_back({(v == 8'h39), 8'(v)});
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_tx_valid"}, {31'h0, o_tx_valid}, 32'h0);
        checkOutput({tag, "_tx_data"},  {24'h0, o_tx_data},  32'h0);
        checkOutput({tag, "_s_ready"},  {31'h0, o_s_ready},  32'h0);
        checkOutput({tag, "_busy"},     {31'h0, o_busy},     32'h0);
        checkOutput({tag, "_len_err"},  {31'h0, o_len_err},  32'h0);
        checkOutput({tag, "_byte_cnt"}, {22'h0, o_byte_cnt}, 32'h0);
        checkOutput({tag, "_buff"},     {22'h0, o_buff},     32'h0);
    endtask

    task automatic clear_models();
        src_q.delete();
        got.delete();
        src_hold   = 1'b0;
        prev_stall = 1'b0;
        hist_model = 10'h0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; send_data = 1'b0; pid = 4'h0; zlp = 1'b0;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; tx_ready = 1'b0;
        sel_b = 1'b0; hold_send = 1'b0; ready_mode = 0; valid_mode = 0;
        clear_models();

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Known-answer packet: C3 31..39 C8 B4
        $display("[TB] known-answer packet");
        load_vector();
        run_packet(4'h3, 1'b0, 1'b0);
        checkOutput("kat_crc_lo", got_at(10), 32'hC8);
        checkOutput("kat_crc_hi", got_at(11), 32'hB4);

        // Zero-length packet must not consume the waiting source byte
        $display("[TB] zero-length packet");
        src_q.push_back({1'b1, 8'hAA});
        run_packet(4'hB, 1'b1, 1'b0);
        checkOutput("zlp_src_left", src_q.size(), 1);
        clear_models();

        // Stall pattern 1,0,0,1 with source bubbles, same vector
        $display("[TB] stalls and bubbles");
        ready_mode = 2; valid_mode = 1;
        load_vector();
        run_packet(4'h3, 1'b0, 1'b0);
        checkOutput("stall_crc_lo", got_at(10), 32'hC8);
        checkOutput("stall_crc_hi", got_at(11), 32'hB4);

        // Random payloads with random back-pressure
        $display("[TB] random packets");
        ready_mode = 1; valid_mode = 1;
        for (int k = 0; k < 4; k++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) src_q.push_back({(j == len - 1), 8'($urandom)});
            run_packet(4'($urandom), 1'b0, 1'b0);
        end

        // send_data held high: two gap cycles, one idle cycle, next PID
        $display("[TB] back-to-back with send_data held");
        ready_mode = 0; valid_mode = 0;
        for (int j = 0; j < 10; j++) src_q.push_back({(j == 4 || j == 9), 8'($urandom)});
        run_packet(4'h5, 1'b0, 1'b1);
        checkOutput("held_gap_pattern", {28'h0, o_buff[3:0]}, 32'hC);
        run_packet(4'hA, 1'b0, 1'b1);
        hold_send = 1'b0;
        send_data = 1'b0;

        // Asynchronous reset in the middle of the payload
        $display("[TB] reset during payload");
        for (int j = 0; j < 20; j++) src_q.push_back({(j == 19), 8'($urandom)});
        pid = 4'h6; zlp = 1'b0; send_data = 1'b1;
        got.delete();
        for (int g = 0; g < 50 && got.size() < 4; g++) applyStimulus();
        #2 reset = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        clear_models();
        load_vector();
        run_packet(4'h3, 1'b0, 1'b0);

        // Truncation at MAX_LEN=4 on the second instance
        $display("[TB] MAX_LEN truncation");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sel_b = 1'b1;
        clear_models();
        for (int v = 8'h41; v <= 8'h46; v++) src_q.push_back({(v == 8'h46), 8'(v)});
        run_packet(4'hC, 1'b0, 1'b0);
        run_packet(4'hC, 1'b0, 1'b0);
        checkOutput("trunc_next_first", got_at(1), 32'h45);
        for (int v = 8'h51; v <= 8'h54; v++) src_q.push_back({(v == 8'h54), 8'(v)});
        run_packet(4'h1, 1'b0, 1'b0);
        ready_mode = 1; valid_mode = 1;
        for (int j = 0; j < 7; j++) src_q.push_back({(j == 6), 8'($urandom)});
        run_packet(4'h2, 1'b0, 1'b0);
        run_packet(4'h2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
